// File: rtl/planta_termica.sv
// Thermal plant model: integrates heater/fan commands into a temperature.
// Optional pseudo-random disturbance when PLANTA_PERTURBACION_EN is defined.
module planta_termica #(
    parameter int TEMP_W      = 10,
    parameter int PASO_CICLOS = 4,
    parameter int T_AMB       = 220,
    parameter int INC_CAL     = 5,
    parameter int DEC_VENT    = 5,
    parameter int TEMP_MIN    = 100,
    parameter int TEMP_MAX    = 350
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              calefactor,
    input  logic              ventilador,
    input  logic              alerta,
    input  logic              carga_valid,
    input  logic [TEMP_W-1:0] carga_temp,
    output logic [TEMP_W-1:0] temp_salida,
    output logic              actualizado,
    output logic [1:0]        modo
);

    typedef enum logic [1:0] {
        REPOSO     = 2'b00,
        CALENTANDO = 2'b01,
        ENFRIANDO  = 2'b10,
        CONFLICTO  = 2'b11
    } modo_t;

    localparam int CW = (PASO_CICLOS > 2) ? $clog2(PASO_CICLOS) : 1;
    localparam int XW = TEMP_W + 1;

    localparam logic [XW-1:0] MIN_X  = XW'(TEMP_MIN);
    localparam logic [XW-1:0] MAX_X  = XW'(TEMP_MAX);
    localparam logic [XW-1:0] AMB_X  = XW'(T_AMB);
    localparam logic [XW-1:0] CAL_X  = XW'(INC_CAL);
    localparam logic [XW-1:0] VENT_X = XW'(DEC_VENT);
    localparam logic [CW-1:0] ULTIMO = CW'(PASO_CICLOS - 1);

    logic [TEMP_W-1:0] temp_q;
    logic [TEMP_W-1:0] temp_d;
    logic [TEMP_W-1:0] carga_d;
    modo_t             modo_q;
    modo_t             modo_d;
    logic              act_q;
    logic [CW-1:0]     cnt_q;
    logic              upd;

    logic [XW-1:0] temp_x;
    logic [XW-1:0] carga_x;
    logic [XW-1:0] paso_cal;
    logic [XW-1:0] paso_vent;
    logic [XW-1:0] nom;

`ifdef PLANTA_PERTURBACION_EN
    logic [7:0] lfsr_q;
    logic       lfsr_fb;

    assign lfsr_fb = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
`endif

    assign upd       = (cnt_q == ULTIMO);
    assign temp_x    = {1'b0, temp_q};
    assign carga_x   = {1'b0, carga_temp};
    assign paso_cal  = alerta ? (CAL_X << 1) : CAL_X;
    assign paso_vent = alerta ? (VENT_X << 1) : VENT_X;

    always_comb begin
        if (carga_x < MIN_X)
            carga_d = TEMP_W'(MIN_X);
        else if (carga_x > MAX_X)
            carga_d = TEMP_W'(MAX_X);
        else
            carga_d = carga_temp;
    end

    always_comb begin
        nom    = temp_x;
        modo_d = REPOSO;
        unique case (1'b1)
            calefactor && ventilador: begin
                nom    = temp_x;
                modo_d = CONFLICTO;
            end
            calefactor && !ventilador: begin
                nom    = temp_x + paso_cal;
                if (nom > MAX_X)
                    nom = MAX_X;
                modo_d = CALENTANDO;
            end
            !calefactor && ventilador: begin
                // Compare before subtracting so the low limit never wraps
                if (temp_x >= MIN_X + paso_vent)
                    nom = temp_x - paso_vent;
                else
                    nom = MIN_X;
                modo_d = ENFRIANDO;
            end
            default: begin
                if (temp_x < AMB_X)
                    nom = temp_x + 1'b1;
                else if (temp_x > AMB_X)
                    nom = temp_x - 1'b1;
                modo_d = REPOSO;
            end
        endcase
`ifdef PLANTA_PERTURBACION_EN
        if (modo_d != CONFLICTO && lfsr_q[1]) begin
            if (lfsr_q[0])
                nom = (nom >= MAX_X) ? MAX_X : nom + 1'b1;
            else
                nom = (nom <= MIN_X) ? MIN_X : nom - 1'b1;
        end
`endif
        temp_d = TEMP_W'(nom);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            temp_q <= TEMP_W'(AMB_X);
            modo_q <= REPOSO;
            act_q  <= 1'b0;
            cnt_q  <= '0;
`ifdef PLANTA_PERTURBACION_EN
            lfsr_q <= 8'hA5;
`endif
        end else if (carga_valid) begin
            temp_q <= carga_d;
            act_q  <= 1'b1;
            cnt_q  <= '0;
        end else begin
            act_q <= upd;
            cnt_q <= upd ? '0 : cnt_q + 1'b1;
            if (upd) begin
                temp_q <= temp_d;
                modo_q <= modo_d;
`ifdef PLANTA_PERTURBACION_EN
                lfsr_q <= {lfsr_q[6:0], lfsr_fb};
`endif
            end
        end
    end

    assign temp_salida = temp_q;
    assign actualizado = act_q;
    assign modo        = modo_q;

endmodule

// File: tb/tb_planta_termica.sv
// Directed self-checking bench for planta_termica (default build).
module tb_planta_termica;

    logic       clk = 1'b0;
    logic       rst;
    logic       calefactor;
    logic       ventilador;
    logic       alerta;
    logic       carga_valid;
    logic [9:0] carga_temp;
    logic [9:0] temp_salida;
    logic       actualizado;
    logic [1:0] modo;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    planta_termica dut (
        .clk         (clk),
        .rst         (rst),
        .calefactor  (calefactor),
        .ventilador  (ventilador),
        .alerta      (alerta),
        .carga_valid (carga_valid),
        .carga_temp  (carga_temp),
        .temp_salida (temp_salida),
        .actualizado (actualizado),
        .modo        (modo)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load(input int v);
        carga_valid = 1'b1;
        carga_temp  = 10'(v);
        cyc(1);
        carga_valid = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        calefactor  = 1'b1;
        ventilador  = 1'b0;
        alerta      = 1'b0;
        carga_valid = 1'b0;
        carga_temp  = '0;

        // reset held two edges with heater on
        cyc(2);
        chk("rst_temp", temp_salida, 220);
        chk("rst_modo", modo, 0);
        chk("rst_act", actualizado, 0);

        // heating: pulses every 4th edge, +5 each
        rst = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            cyc(1);
            chk("heat_act", actualizado, (i % 4 == 0) ? 1 : 0);
            chk("heat_temp", temp_salida, 220 + 5 * (i / 4));
        end
        chk("heat_modo", modo, 1);

        // load 220: modo unchanged
        calefactor = 1'b0;
        carga_valid = 1'b1;
        carga_temp = 10'd220;
        cyc(1);
        chk("load_temp", temp_salida, 220);
        chk("load_act", actualizado, 1);
        chk("load_modo", modo, 1);
        carga_valid = 1'b0;

        // cooling with alert: -10 per update
        ventilador = 1'b1;
        alerta     = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            cyc(1);
            chk("cool_act", actualizado, (i % 4 == 0) ? 1 : 0);
            chk("cool_temp", temp_salida, 220 - 10 * (i / 4));
        end
        chk("cool_modo", modo, 2);

        // upper saturation
        ventilador = 1'b0;
        alerta     = 1'b0;
        calefactor = 1'b1;
        load(345);
        chk("sat_load", temp_salida, 345);
        cyc(4);
        chk("sat_hi1", temp_salida, 350);
        chk("sat_hi1_act", actualizado, 1);
        cyc(4);
        chk("sat_hi2", temp_salida, 350);
        chk("sat_modo", modo, 1);

        // load clamping both ends
        load(90);
        chk("clamp_lo", temp_salida, 100);
        load(400);
        chk("clamp_hi", temp_salida, 350);

        // lower saturation on cooling with alert
        calefactor = 1'b0;
        ventilador = 1'b1;
        alerta     = 1'b1;
        load(102);
        chk("sat_lo_load", temp_salida, 102);
        cyc(4);
        chk("sat_lo", temp_salida, 100);
        chk("sat_lo_modo", modo, 2);

        // load landing on an update edge suppresses the update
        cyc(3);
        chk("pre_upd_act", actualizado, 0);
        load(150);
        chk("ld_upd_temp", temp_salida, 150);
        chk("ld_upd_modo", modo, 2);
        chk("ld_upd_act", actualizado, 1);
        ventilador = 1'b0;
        alerta     = 1'b0;
        calefactor = 1'b1;
        cyc(3);
        chk("after_ld_act", actualizado, 0);
        chk("after_ld_temp", temp_salida, 150);
        cyc(1);
        chk("after_ld_upd", temp_salida, 155);
        chk("after_ld_modo", modo, 1);

        // conflict: both on, temp held
        ventilador = 1'b1;
        cyc(4);
        chk("conf_temp", temp_salida, 155);
        chk("conf_modo", modo, 3);
        chk("conf_act", actualizado, 1);

        // drift toward ambient after a mid-period load
        cyc(2);
        calefactor = 1'b0;
        ventilador = 1'b0;
        load(223);
        chk("drift_load", temp_salida, 223);
        chk("drift_ld_modo", modo, 3);
        for (int i = 1; i <= 16; i++) begin
            cyc(1);
            chk("drift_act", actualizado, (i % 4 == 0) ? 1 : 0);
            chk("drift_temp", temp_salida,
                223 - ((i / 4) > 3 ? 3 : (i / 4)));
        end
        chk("drift_modo", modo, 0);

        // reset mid-operation, overriding a load
        load(300);
        cyc(2);
        calefactor  = 1'b1;
        rst         = 1'b1;
        carga_valid = 1'b1;
        carga_temp  = 10'd333;
        cyc(1);
        chk("mrst_temp", temp_salida, 220);
        chk("mrst_modo", modo, 0);
        chk("mrst_act", actualizado, 0);
        rst         = 1'b0;
        carga_valid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            cyc(1);
            chk("mrst_pulse", actualizado, (i == 4) ? 1 : 0);
            chk("mrst_heat", temp_salida, (i == 4) ? 225 : 220);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
